// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage pipelined MIPS core.
//
// Holds the E/M pipeline register, a word-addressed data memory with
// configurable access latency, and the M/W pipeline register that feeds
// writeback. While a load/store is waiting on the memory, StallM asks the
// hazard unit to freeze F/D/E, and a bubble is sent into W.
//
// Parameters
//   DEPTH        data memory size in 32-bit words (power of 2)
//   ADDR_W       log2(DEPTH); word index = ALUOutM[ADDR_W+1:2]
//   MEM_LATENCY  extra stall cycles per load/store (0 = single-cycle memory)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   RegWriteE, MemtoRegE,      control from execute_stage
//   MemWriteE
//   ALUOutE, WriteDataE,       address/result, store data, destination reg
//   WriteRegE
//   RegWriteM, MemtoRegM,      E/M register outputs; ALUOutM/WriteRegM/RegWriteM
//   MemWriteM, ALUOutM,        also feed forwarding and the hazard unit
//   WriteRegM
//   StallM                     memory access in progress
//   AlignErrM                  memory op in M with a non-word-aligned address
//   RegWriteW, MemtoRegW,      M/W register outputs to writeback
//   ReadDataW, ALUOutW,
//   WriteRegW
module memory_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        StallM,
  output logic        AlignErrM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW
);

  // A zero-latency build still needs a 1-bit counter so the compare below is legal.
  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        writeDataM;
  logic               memOp;
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        readData;
  logic [31:0]        mem [DEPTH];

  // A load with MemWrite also set is handled as a store by the write port;
  // either flag alone makes the instruction occupy the memory.
  assign memOp     = MemtoRegM | MemWriteM;
  assign StallM    = memOp & (cnt != LAT_C);
  assign AlignErrM = memOp & (|ALUOutM[1:0]);
  // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
  assign idx       = ALUOutM[ADDR_W+1:2];
  assign readData  = mem[idx];

  // ---- E -> M boundary: E/M register, frozen while the access is stalled ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      writeDataM <= '0;
      WriteRegM  <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= ALUOutE;
      writeDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
    end
  end

  // Access-latency FSM. cnt counts the stall cycles already spent; the cycle
  // where cnt reaches MEM_LATENCY is the completion cycle (StallM low).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memOp && (MEM_LATENCY > 0)) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt < LAT_C) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Store commits only on the edge that ends the completion cycle; a reset on
  // that edge abandons it.
  always_ff @(posedge clk) begin
    if (rst_n && MemWriteM && !StallM) begin
      mem[idx] <= writeDataM;
    end
  end

  // ---- M -> W boundary: M/W register; a stalled cycle sends a bubble ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else if (!StallM) begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ReadDataW <= readData;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
    end else begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main DUT (MEM_LATENCY = LAT)
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        RegWriteM, MemtoRegM, MemWriteM, StallM, AlignErrM;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  // Single-cycle memory DUT (MEM_LATENCY = 0)
  logic        RegWriteEZ, MemtoRegEZ, MemWriteEZ;
  logic [31:0] ALUOutEZ, WriteDataEZ;
  logic [4:0]  WriteRegEZ;
  logic        RegWriteMZ, MemtoRegMZ, MemWriteMZ, StallMZ, AlignErrMZ;
  logic [31:0] ALUOutMZ;
  logic [4:0]  WriteRegMZ;
  logic        RegWriteWZ, MemtoRegWZ;
  logic [31:0] ReadDataWZ, ALUOutWZ;
  logic [4:0]  WriteRegWZ;

  memory_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .StallM(StallM), .AlignErrM(AlignErrM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  memory_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(0)) dutZ (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteEZ), .MemtoRegE(MemtoRegEZ), .MemWriteE(MemWriteEZ),
    .ALUOutE(ALUOutEZ), .WriteDataE(WriteDataEZ), .WriteRegE(WriteRegEZ),
    .RegWriteM(RegWriteMZ), .MemtoRegM(MemtoRegMZ), .MemWriteM(MemWriteMZ),
    .ALUOutM(ALUOutMZ), .WriteRegM(WriteRegMZ), .StallM(StallMZ), .AlignErrM(AlignErrMZ),
    .RegWriteW(RegWriteWZ), .MemtoRegW(MemtoRegWZ), .ReadDataW(ReadDataWZ),
    .ALUOutW(ALUOutWZ), .WriteRegW(WriteRegWZ)
  );

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        m2r;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t qz[$];
  int total = 0;
  int bad = 0;
  int lastStalls;
  logic zActive = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Writeback monitors: every W-stage valid result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && RegWriteW) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w_unexpected: got result alu=0x%08h reg=%0d expected none", ALUOutW, WriteRegW);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ALUOutW", ALUOutW, e.alu);
        chk("WriteRegW", 32'(WriteRegW), 32'(e.wr));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(e.m2r));
        if (e.m2r) chk("ReadDataW", ReadDataW, e.rd);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && RegWriteWZ) begin
      if (qz.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wz_unexpected: got result alu=0x%08h reg=%0d expected none", ALUOutWZ, WriteRegWZ);
      end else begin
        exp_t e;
        e = qz.pop_front();
        chk("ALUOutWZ", ALUOutWZ, e.alu);
        chk("WriteRegWZ", 32'(WriteRegWZ), 32'(e.wr));
        chk("MemtoRegWZ", 32'(MemtoRegWZ), 32'(e.m2r));
        if (e.m2r) chk("ReadDataWZ", ReadDataWZ, e.rd);
      end
    end
    if (rst_n && zActive) chk("StallMZ_never", 32'(StallMZ), 32'd0);
  end

  // Drive one instruction at posedge+1 and hold it until the stage accepts it.
  // lastStalls = stall cycles spent by the instruction that was already in M.
  task automatic issue(input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr);
    int s;
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw;
    ALUOutE = a; WriteDataE = wd; WriteRegE = wr;
    s = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!StallM) break;
      s++;
    end
    if (StallM) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got StallM stuck for %0d cycles expected release", s);
    end
    lastStalls = s;
    @(posedge clk); #1;
  endtask

  task automatic aluOp(input logic [31:0] a, input logic [4:0] wr);
    q.push_back('{alu: a, wr: wr, m2r: 1'b0, rd: 32'h0});
    issue(1'b1, 1'b0, 1'b0, a, 32'h0, wr);
  endtask

  task automatic loadOp(input logic [31:0] a, input logic [4:0] wr, input logic [31:0] d);
    q.push_back('{alu: a, wr: wr, m2r: 1'b1, rd: d});
    issue(1'b1, 1'b1, 1'b0, a, 32'h0, wr);
  endtask

  task automatic storeOp(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 1'b0, 1'b1, a, d, 5'd0);
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Single-cycle DUT: one instruction per clock, no handshake needed.
  task automatic zDrive(input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr);
    if (rw) qz.push_back('{alu: a, wr: wr, m2r: m2r, rd: wd});
    RegWriteEZ = rw; MemtoRegEZ = m2r; MemWriteEZ = mw;
    ALUOutEZ = a; WriteDataEZ = mw ? wd : 32'h0; WriteRegEZ = wr;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RegWriteEZ = 0; MemtoRegEZ = 0; MemWriteEZ = 0;
    ALUOutEZ = 0; WriteDataEZ = 0; WriteRegEZ = 0;

    // Reset with random E inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom); MemWriteE = 1'($urandom);
      ALUOutE = $urandom; WriteDataE = $urandom; WriteRegE = 5'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("rst_MemtoRegM", 32'(MemtoRegM), 32'd0);
    chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
    chk("rst_ALUOutM", ALUOutM, 32'd0);
    chk("rst_WriteRegM", 32'(WriteRegM), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_AlignErrM", 32'(AlignErrM), 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_MemtoRegW", 32'(MemtoRegW), 32'd0);
    chk("rst_ReadDataW", ReadDataW, 32'd0);
    chk("rst_ALUOutW", ALUOutW, 32'd0);
    chk("rst_WriteRegW", 32'(WriteRegW), 32'd0);
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    ALUOutE = 0; WriteDataE = 0; WriteRegE = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU result passes straight through
    aluOp(32'h2A, 5'd5);
    chk("alu_ALUOutM", ALUOutM, 32'h2A);
    chk("alu_RegWriteM", 32'(RegWriteM), 32'd1);
    chk("alu_StallM", 32'(StallM), 32'd0);
    nop();
    chk("alu_no_stall", 32'(lastStalls), 32'd0);

    // Store then back-to-back load of the same word
    storeOp(32'h10, 32'hDEADBEEF);
    chk("store_StallM_on_entry", 32'(StallM), 32'd1);
    loadOp(32'h10, 5'd7, 32'hDEADBEEF);
    chk("store_stall_cycles", 32'(lastStalls), 32'(LAT));
    nop();
    chk("load_stall_cycles", 32'(lastStalls), 32'(LAT));
    nop();

    // E/M holds while stalled even as E inputs churn
    loadOp(32'h10, 5'd9, 32'hDEADBEEF);
    for (int i = 0; i < LAT; i++) begin
      RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom); MemWriteE = 1'($urandom);
      ALUOutE = $urandom; WriteDataE = $urandom; WriteRegE = 5'($urandom);
      @(negedge clk);
      chk("hold_StallM", 32'(StallM), 32'd1);
      chk("hold_ALUOutM", ALUOutM, 32'h10);
      chk("hold_WriteRegM", 32'(WriteRegM), 32'd9);
      chk("hold_MemtoRegM", 32'(MemtoRegM), 32'd1);
      @(posedge clk); #1;
    end
    aluOp(32'h77, 5'd3);
    chk("release_ALUOutM", ALUOutM, 32'h77);
    chk("release_WriteRegM", 32'(WriteRegM), 32'd3);
    nop();

    // Address wrap and misalignment
    storeOp(32'h400, 32'h1234);
    loadOp(32'h000, 5'd2, 32'h1234);
    chk("aligned_AlignErrM", 32'(AlignErrM), 32'd0);
    loadOp(32'h012, 5'd4, 32'hDEADBEEF);
    chk("misaligned_AlignErrM", 32'(AlignErrM), 32'd1);
    @(negedge clk);
    chk("misaligned_AlignErrM_held", 32'(AlignErrM), 32'd1);
    @(posedge clk); #1;
    nop();
    nop();

    // Reset during a pending store abandons it
    storeOp(32'h20, 32'h1);
    nop();
    nop();
    nop();
    storeOp(32'h20, 32'hFFFF);
    chk("abort_StallM_before", 32'(StallM), 32'd1);
    rst_n = 1'b0;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    ALUOutE = 0; WriteDataE = 0; WriteRegE = 0;
    @(posedge clk); #1;
    chk("abort_StallM_after", 32'(StallM), 32'd0);
    chk("abort_MemWriteM", 32'(MemWriteM), 32'd0);
    rst_n = 1'b1;
    loadOp(32'h20, 5'd6, 32'h1);
    nop();
    nop();

    // Single-cycle memory build
    zActive = 1'b1;
    zDrive(1'b0, 1'b0, 1'b1, 32'h8, 32'h55, 5'd0);
    zDrive(1'b1, 1'b1, 1'b0, 32'h8, 32'h55, 5'd1);
    zDrive(1'b1, 1'b0, 1'b0, 32'h9, 32'h0, 5'd2);
    zDrive(1'b1, 1'b1, 1'b0, 32'h8, 32'h55, 5'd3);
    zDrive(1'b0, 1'b0, 1'b1, 32'hC, 32'h66, 5'd0);
    zDrive(1'b1, 1'b1, 1'b0, 32'hC, 32'h66, 5'd4);
    zDrive(1'b1, 1'b1, 1'b0, 32'h408, 32'h55, 5'd5);
    zDrive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    zDrive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    zActive = 1'b0;

    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("queueZ_drained", 32'(qz.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
